// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: IF-side push handshake, ID-side pop handshake, flush and status.
// The queue connects through the slave modport. The IF/ID side, or the bench, connects through master.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_inst;
    logic              if_ready;
    logic              flush;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              id_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output if_valid, if_pc, if_inst, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count, overflow
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count, overflow
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// In-order {pc, inst} buffer between the IF and ID stages, built as a circular buffer.
// if_ready back-pressures IF, and a flush discards every wrong-path entry.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // if_ready ignores a same-cycle pop, so a full queue never accepts a push.
    assign bus.if_ready = ~full;
    assign bus.id_valid = ~empty & ~bus.flush;
    assign push         = bus.if_valid & ~full & ~bus.flush;
    assign pop          = bus.id_valid & bus.id_ready;

    assign bus.id_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign bus.id_inst  = empty ? '0 : inst_mem[rd_ptr];
    assign bus.count    = cnt;
    assign bus.overflow = ovf;

    // Storage is left unreset; empty masks the read data.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.if_pc;
            inst_mem[wr_ptr] <= bus.if_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (bus.if_valid && full) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
